// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS debug-unit pipeline controller:
// command codes, the HALT opcode, FSM states and default sizes.
package mips_dbg_pkg;

   localparam int unsigned DATA_WIDTH_DEF   = 32;
   localparam int unsigned ADDR_WIDTH_DEF   = 5;
   localparam int unsigned NUM_REGS_DEF     = 32;
   localparam int unsigned DRAIN_CYCLES_DEF = 3;

   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_RUN  = 2'b01;
   localparam logic [1:0] CMD_STEP = 2'b10;
   localparam logic [1:0] CMD_DUMP = 2'b11;

   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUN       = 3'd1,
      ST_STEP      = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_DUMP_RD   = 3'd4,
      ST_DUMP_SEND = 3'd5,
      ST_DONE      = 3'd6
   } state_e;

endpackage

// File: rtl/reg_dump_streamer.sv
// Walks the register bank debug port and presents one word at a time on a
// valid/ready stream; address, data, valid and last are all registered.
module reg_dump_streamer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_REGS   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  capture_i,
   input  logic                  send_i,
   input  logic [DATA_WIDTH-1:0] reg_data_i,
   output logic [ADDR_WIDTH-1:0] reg_addr_o,
   output logic                  dump_valid_o,
   output logic [DATA_WIDTH-1:0] dump_data_o,
   output logic                  dump_last_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  last_q, last_d;

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      if (start_i) begin
         addr_d = '0;
      end else if (capture_i) begin
         data_d  = reg_data_i;
         valid_d = 1'b1;
         last_d  = (addr_q == LAST_ADDR);
      end else if (send_i && valid_q) begin
         // Word accepted: retire it and either rewind or advance.
         valid_d = 1'b0;
         last_d  = 1'b0;
         addr_d  = last_q ? '0 : addr_q + ADDR_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end

   assign reg_addr_o   = addr_q;
   assign dump_valid_o = valid_q;
   assign dump_data_o  = data_q;
   assign dump_last_o  = last_q;

endmodule

// File: rtl/pipeline_exec_controller.sv
// Debug-unit sequencer for the 5-stage pipeline: run/step/dump commands,
// HALT drain-and-park, pipeline freeze line and unfrozen-cycle counter.
module pipeline_exec_controller
   import mips_dbg_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int unsigned NUM_REGS     = NUM_REGS_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_cmd_valid,
   input  logic [1:0]            i_cmd,
   output logic                  o_cmd_ready,
   input  logic                  i_halt_in_id,
   output logic                  o_halt,
   output logic [ADDR_WIDTH-1:0] o_dbg_reg_addr,
   input  logic [DATA_WIDTH-1:0] i_dbg_reg_data,
   output logic                  o_dump_valid,
   output logic [DATA_WIDTH-1:0] o_dump_data,
   output logic                  o_dump_last,
   input  logic                  i_dump_ready,
   output logic                  o_program_done,
   output logic [31:0]           o_cycle_count
);

   localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   state_e           state_q, state_d;
   logic             rest_done_q, rest_done_d;
   logic [CNT_W-1:0] drain_q, drain_d;
   logic             halt_q, halt_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
   logic [31:0]      cyc_q, cyc_d;
   logic             cmd_fire_c, dump_start_c, dump_capture_c, dump_send_c;

   always_comb begin
      state_d      = state_q;
      rest_done_d  = rest_done_q;
      drain_d      = drain_q;
      done_d       = done_q;
      dump_start_c = 1'b0;
      cmd_fire_c   = i_cmd_valid && ready_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // From DONE only DUMP leaves; RUN/STEP are swallowed.
            if (cmd_fire_c) begin
               case (i_cmd)
                  CMD_RUN:  if (state_q == ST_IDLE) state_d = ST_RUN;
                  CMD_STEP: if (state_q == ST_IDLE) state_d = ST_STEP;
                  CMD_DUMP: begin
                     state_d      = ST_DUMP_RD;
                     rest_done_d  = (state_q == ST_DONE);
                     dump_start_c = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (i_halt_in_id) begin
               state_d = ST_DRAIN;
               drain_d = CNT_W'(DRAIN_CYCLES - 1);
            end
         end
         ST_STEP: begin
            if (i_halt_in_id) begin
               state_d = ST_DRAIN;
               drain_d = CNT_W'(DRAIN_CYCLES - 1);
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            drain_d = (drain_q != '0) ? drain_q - CNT_W'(1) : '0;
            if (drain_q <= CNT_W'(1)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DUMP_RD: state_d = ST_DUMP_SEND;
         ST_DUMP_SEND: begin
            if (i_dump_ready) begin
               if (o_dump_last) state_d = rest_done_q ? ST_DONE : ST_IDLE;
               else             state_d = ST_DUMP_RD;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      halt_d  = !(state_d inside {ST_RUN, ST_STEP, ST_DRAIN});
      ready_d = (state_d inside {ST_IDLE, ST_DONE});
      cyc_d   = (!halt_q && (cyc_q != 32'hFFFF_FFFF)) ? cyc_q + 32'd1 : cyc_q;
   end

   assign dump_capture_c = (state_q == ST_DUMP_RD);
   assign dump_send_c    = (state_q == ST_DUMP_SEND) && i_dump_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         rest_done_q <= 1'b0;
         drain_q     <= '0;
         halt_q      <= 1'b1;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         cyc_q       <= '0;
      end else begin
         state_q     <= state_d;
         rest_done_q <= rest_done_d;
         drain_q     <= drain_d;
         halt_q      <= halt_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         cyc_q       <= cyc_d;
      end
   end

   reg_dump_streamer #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_streamer (
      .clk_i        (i_clk),
      .rst_i        (i_reset),
      .start_i      (dump_start_c),
      .capture_i    (dump_capture_c),
      .send_i       (dump_send_c),
      .reg_data_i   (i_dbg_reg_data),
      .reg_addr_o   (o_dbg_reg_addr),
      .dump_valid_o (o_dump_valid),
      .dump_data_o  (o_dump_data),
      .dump_last_o  (o_dump_last)
   );

   assign o_halt         = halt_q;
   assign o_cmd_ready    = ready_q;
   assign o_program_done = done_q;
   assign o_cycle_count  = cyc_q;

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller: reset, step, run-to-HALT,
// DONE command filtering, register dump with and without consumer stalls.
module tb_pipeline_exec_controller;
   import mips_dbg_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic [1:0]  cmd;
   logic        cmd_ready;
   logic        halt_in_id;
   logic        halt;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data;
   logic        dump_valid;
   logic [31:0] dump_data;
   logic        dump_last;
   logic        dump_ready;
   logic        prog_done;
   logic [31:0] cyc;

   int total = 0;
   int bad   = 0;

   localparam logic [73:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 32'd0};

   always #5 clk = ~clk;

   // Register bank model: r[k] = k * 0x1111
   assign reg_data = 32'(reg_addr) * 32'h1111;

   pipeline_exec_controller dut (
      .i_clk          (clk),
      .i_reset        (rst),
      .i_cmd_valid    (cmd_valid),
      .i_cmd          (cmd),
      .o_cmd_ready    (cmd_ready),
      .i_halt_in_id   (halt_in_id),
      .o_halt         (halt),
      .o_dbg_reg_addr (reg_addr),
      .i_dbg_reg_data (reg_data),
      .o_dump_valid   (dump_valid),
      .o_dump_data    (dump_data),
      .o_dump_last    (dump_last),
      .i_dump_ready   (dump_ready),
      .o_program_done (prog_done),
      .o_cycle_count  (cyc)
   );

   // Called at a negedge; returns at the negedge of the first cycle after acceptance.
   task automatic send_cmd(input logic [1:0] c);
      cmd_valid = 1'b1;
      cmd       = c;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [73:0] obs;
      #1;
      obs = {halt, cmd_ready, dump_valid, dump_last, dump_data, reg_addr, prog_done, cyc};
      total++;
      if (obs !== RESET_VEC) begin
         bad++;
         $display("FAIL reset_initial got=%h exp=%h", obs, RESET_VEC);
      end
      @(negedge clk);
      rst = 1'b0;
      send_cmd(CMD_RUN);
      total++;
      if (halt !== 1'b0) begin
         bad++;
         $display("FAIL reset_run_unfreeze got=%b exp=0", halt);
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      obs = {halt, cmd_ready, dump_valid, dump_last, dump_data, reg_addr, prog_done, cyc};
      total++;
      if (obs !== RESET_VEC) begin
         bad++;
         $display("FAIL reset_midcycle got=%h exp=%h", obs, RESET_VEC);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_step();
      for (int i = 0; i < 3; i++) begin
         send_cmd(CMD_STEP);
         total++;
         if ({halt, cmd_ready} !== 2'b00) begin
            bad++;
            $display("FAIL step%0d_active halt/ready got=%b exp=00", i, {halt, cmd_ready});
         end
         @(negedge clk);
         total++;
         if ({halt, cmd_ready} !== 2'b11) begin
            bad++;
            $display("FAIL step%0d_refreeze halt/ready got=%b exp=11", i, {halt, cmd_ready});
         end
      end
      total++;
      if (cyc !== 32'd3) begin
         bad++;
         $display("FAIL step_cycle_count got=%0d exp=3", cyc);
      end
   endtask

   task automatic test_run_halt();
      cmd_valid = 1'b1;
      cmd       = CMD_RUN;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         cmd_valid  = 1'b0;
         halt_in_id = (c == 10);
         total++;
         if ({halt, prog_done} !== {(c >= 13), (c >= 13)}) begin
            bad++;
            $display("FAIL run_cycle%0d halt/done got=%b exp=%b", c, {halt, prog_done},
                     {(c >= 13), (c >= 13)});
         end
      end
      halt_in_id = 1'b0;
      total++;
      if (cyc !== 32'd15) begin
         bad++;
         $display("FAIL run_cycle_count got=%0d exp=15", cyc);
      end
   endtask

   task automatic test_done_cmds();
      send_cmd(CMD_RUN);
      total++;
      if ({halt, cmd_ready, prog_done} !== 3'b111) begin
         bad++;
         $display("FAIL done_run_ignored got=%b exp=111", {halt, cmd_ready, prog_done});
      end
      send_cmd(CMD_STEP);
      @(negedge clk);
      total++;
      if ({halt, cmd_ready, cyc} !== {2'b11, 32'd15}) begin
         bad++;
         $display("FAIL done_step_ignored halt=%b ready=%b cyc=%0d exp 1 1 15", halt, cmd_ready, cyc);
      end
   endtask

   task automatic test_dump_from_done();
      int k = 0;
      int n = 0;
      dump_ready = 1'b1;
      cmd_valid  = 1'b1;
      cmd        = CMD_DUMP;
      while (k < 32 && n < 300) begin
         @(negedge clk);
         n++;
         cmd       = CMD_STEP;
         cmd_valid = (n == 12);
         total++;
         if ({halt, cmd_ready} !== 2'b10) begin
            bad++;
            $display("FAIL dump_busy n=%0d halt/ready got=%b exp=10", n, {halt, cmd_ready});
         end
         if (dump_valid) begin
            total++;
            if ({dump_data, dump_last} !== {32'(k) * 32'h1111, (k == 31)}) begin
               bad++;
               $display("FAIL dump_word%0d data=%h last=%b exp data=%h last=%b", k, dump_data,
                        dump_last, 32'(k) * 32'h1111, (k == 31));
            end
            k++;
         end
      end
      cmd_valid = 1'b0;
      total++;
      if (k != 32) begin
         bad++;
         $display("FAIL dump_timeout words=%0d exp=32", k);
      end
      @(negedge clk);
      total++;
      if ({halt, cmd_ready, prog_done, dump_valid, reg_addr, cyc} !== {4'b1110, 5'd0, 32'd15}) begin
         bad++;
         $display("FAIL dump_return_done halt=%b ready=%b done=%b valid=%b addr=%0d cyc=%0d",
                  halt, cmd_ready, prog_done, dump_valid, reg_addr, cyc);
      end
   endtask

   task automatic test_dump_stall();
      int k = 0;
      int n = 0;
      int stall = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      dump_ready = 1'b1;
      cmd_valid  = 1'b1;
      cmd        = CMD_DUMP;
      while (k < 32 && n < 300) begin
         @(negedge clk);
         n++;
         cmd_valid = 1'b0;
         total++;
         if (halt !== 1'b1) begin
            bad++;
            $display("FAIL stall_halt n=%0d got=%b exp=1", n, halt);
         end
         if (dump_valid) begin
            total++;
            if ({dump_data, dump_last} !== {32'(k) * 32'h1111, (k == 31)}) begin
               bad++;
               $display("FAIL stall_word%0d data=%h last=%b exp data=%h last=%b", k, dump_data,
                        dump_last, 32'(k) * 32'h1111, (k == 31));
            end
            if (k == 7 && stall < 5) begin
               dump_ready = 1'b0;
               stall++;
            end else begin
               dump_ready = 1'b1;
               k++;
            end
         end else begin
            dump_ready = 1'b1;
         end
      end
      total++;
      if (k != 32 || stall != 5) begin
         bad++;
         $display("FAIL stall_timeout words=%0d stalls=%0d exp 32 5", k, stall);
      end
      @(negedge clk);
      total++;
      if ({halt, cmd_ready, prog_done, dump_valid, cyc} !== {4'b1100, 32'd0}) begin
         bad++;
         $display("FAIL stall_return_idle halt=%b ready=%b done=%b valid=%b cyc=%0d exp 1 1 0 0 0",
                  halt, cmd_ready, prog_done, dump_valid, cyc);
      end
   endtask

   task automatic test_reset_mid_dump();
      logic [73:0] obs;
      int k = 0;
      int n = 0;
      dump_ready = 1'b1;
      cmd_valid  = 1'b1;
      cmd        = CMD_DUMP;
      while (!(dump_valid && k == 3) && n < 50) begin
         @(negedge clk);
         n++;
         cmd_valid = 1'b0;
         if (dump_valid && k < 3) k++;
      end
      total++;
      if (!(dump_valid && k == 3)) begin
         bad++;
         $display("FAIL middump_reach_word3 words=%0d valid=%b", k, dump_valid);
      end
      #2 rst = 1'b1;
      #1;
      obs = {halt, cmd_ready, dump_valid, dump_last, dump_data, reg_addr, prog_done, cyc};
      total++;
      if (obs !== RESET_VEC) begin
         bad++;
         $display("FAIL middump_reset got=%h exp=%h", obs, RESET_VEC);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({cmd_ready, dump_valid, reg_addr} !== {2'b10, 5'd0}) begin
         bad++;
         $display("FAIL middump_after ready=%b valid=%b addr=%0d exp 1 0 0", cmd_ready, dump_valid,
                  reg_addr);
      end
   endtask

   initial begin
      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd        = CMD_NONE;
      halt_in_id = 1'b0;
      dump_ready = 1'b0;
      test_reset();
      test_step();
      test_run_halt();
      test_done_cmds();
      test_dump_from_done();
      test_dump_stall();
      test_reset_mid_dump();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
